jt51_slotreg: RTL

JT51_SLOTREG -- requirements
Module: jt51_slotreg

---
 rtl/jt51_slotreg_pkg.sv | 33 +++
 rtl/jt51_slotreg_merge.sv | 13 +
 rtl/jt51_slotreg.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/jt51_slotreg_pkg.sv
// Shared types and sizing helpers for the slot register file.
package jt51_slotreg_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam int CH_DEF  = 8;
    localparam int OPS_DEF = 4;

    function automatic int slots_of(input int ch, input int ops);
        return ch * ops;
    endfunction

    function automatic int sw_of(input int ch, input int ops);
        return $clog2(ch * ops);
    endfunction

    function automatic int cw_of(input int ch);
        return $clog2(ch);
    endfunction

    function automatic int ow_of(input int ops);
        return (ops > 1) ? $clog2(ops) : 1;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jt51_slotreg_merge.sv
// Masked read-modify-write merge of one register entry.
module jt51_slotreg_merge #(
    parameter int W = 8
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] data,
    input  logic [W-1:0] mask,
    output logic [W-1:0] merged
);

    assign merged = (prev & ~mask) | (data & mask);

endmodule

// File: rtl/jt51_slotreg.sv
// Time-multiplexed operator/channel register file with a rotating slot
// counter, power-up clear sweep and a single deferred masked write.
module jt51_slotreg
    import jt51_slotreg_pkg::*;
#(
    parameter  int CH    = 8,
    parameter  int OPS   = 4,
    parameter  int OPW   = 42,
    parameter  int CHW   = 26,
    localparam int SLOTS = slots_of(CH, OPS),
    localparam int SW    = sw_of(CH, OPS),
    localparam int CW    = cw_of(CH),
    localparam int OW    = ow_of(OPS),
    localparam int DW    = max_of(OPW, CHW)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           wr_req,
    output logic           wr_ack,
    input  logic           wr_ch_sel,
    input  logic [SW-1:0]  wr_slot,
    input  logic [DW-1:0]  wr_data,
    input  logic [DW-1:0]  wr_mask,
    output logic           busy,
    output logic [SW-1:0]  cur_slot,
    output logic [OW-1:0]  cur_op,
    output logic [CW-1:0]  cur_ch,
    output logic           zero,
    output logic [OPW-1:0] op_dout,
    output logic [CHW-1:0] ch_dout
);

    state_t         st;
    logic [SW-1:0]  slot_q;
    logic [SW-1:0]  nxt;
    logic [CW-1:0]  ch_cur;
    logic [CW-1:0]  ch_nxt;

    logic           p_sel;
    logic [SW-1:0]  p_slot;
    logic [DW-1:0]  p_data;
    logic [DW-1:0]  p_mask;

    logic [OPW-1:0] op_ram [SLOTS];
    logic [CHW-1:0] ch_ram [CH];
    logic [OPW-1:0] op_old;
    logic [OPW-1:0] op_new;
    logic [CHW-1:0] ch_old;
    logic [CHW-1:0] ch_new;

    logic           hit;
    logic           commit;
    logic           clear;

    assign nxt    = slot_q + SW'(1);
    assign ch_cur = slot_q[CW-1:0];
    assign ch_nxt = nxt[CW-1:0];

    assign op_old = op_ram[slot_q];
    assign ch_old = ch_ram[ch_cur];

    jt51_slotreg_merge #(.W(OPW)) u_op_merge (
        .prev   (op_old),
        .data   (p_data[OPW-1:0]),
        .mask   (p_mask[OPW-1:0]),
        .merged (op_new)
    );

    jt51_slotreg_merge #(.W(CHW)) u_ch_merge (
        .prev   (ch_old),
        .data   (p_data[CHW-1:0]),
        .mask   (p_mask[CHW-1:0]),
        .merged (ch_new)
    );

    // Channel writes match on the channel bits only, any operator.
    assign hit    = p_sel ? (ch_cur == p_slot[CW-1:0])
                          : (slot_q == p_slot);
    assign commit = cen && (st == ST_PEND) && hit;
    assign clear  = cen && (st == ST_INIT);

    assign wr_ack   = cen && wr_req && (st == ST_IDLE);
    assign busy     = (st != ST_IDLE);
    assign cur_slot = slot_q;
    assign cur_ch   = ch_cur;
    assign zero     = (slot_q == '0);

    if (OPS > 1) begin : g_op
        assign cur_op = slot_q[SW-1:CW];
    end else begin : g_op1
        assign cur_op = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            op_ram[slot_q] <= '0;
            ch_ram[ch_cur] <= '0;
        end else if (commit) begin
            if (p_sel)
                ch_ram[ch_cur] <= ch_new;
            else
                op_ram[slot_q] <= op_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_INIT;
            slot_q  <= '0;
            op_dout <= '0;
            ch_dout <= '0;
            p_sel   <= 1'b0;
            p_slot  <= '0;
            p_data  <= '0;
            p_mask  <= '0;
        end else if (cen) begin
            slot_q <= nxt;
            // RAM holds garbage until the sweep finishes; hide it.
            op_dout <= (st == ST_INIT) ? '0 : op_ram[nxt];
            ch_dout <= (st == ST_INIT) ? '0 : ch_ram[ch_nxt];
            unique case (st)
                ST_INIT: begin
                    if (slot_q == SW'(SLOTS - 1))
                        st <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (wr_req) begin
                        st     <= ST_PEND;
                        p_sel  <= wr_ch_sel;
                        p_slot <= wr_slot;
                        p_data <= wr_data;
                        p_mask <= wr_mask;
                    end
                end
                ST_PEND: begin
                    if (hit)
                        st <= ST_IDLE;
                end
                default: st <= ST_INIT;
            endcase
        end
    end

endmodule
